// File: rtl/xcfi_pkg.sv
// ----------------------------------------------------------------------------
// xcfi_pkg
// Shared types for the XCFI trace sampler slice: the stored retirement record,
// the sampler state encoding and the RVFI order width.
// Record field widths are fixed here. The sampler's XLEN/ILEN parameters
// default to these values and must stay equal to them.
// ----------------------------------------------------------------------------
package xcfi_pkg;

   localparam int XCFI_ORDER_W = 64;
   localparam int XCFI_XLEN    = 32;
   localparam int XCFI_ILEN    = 32;

   typedef enum logic [1:0] {
      XCFI_IDLE    = 2'd0,
      XCFI_COLLECT = 2'd1,
      XCFI_HOLD    = 2'd2
   } xcfi_smp_state_t;

   typedef struct packed {
      logic [XCFI_ORDER_W-1:0] order;
      logic [XCFI_ILEN-1:0]    insn;
      logic                    trap;
      logic [XCFI_XLEN-1:0]    pc_rdata;
      logic [XCFI_XLEN-1:0]    pc_wdata;
      logic [4:0]              rd_addr;
      logic [XCFI_XLEN-1:0]    rd_wdata;
   } xcfi_trace_rec_t;

endpackage

// File: rtl/xcfi_trace_fifo.sv
// ----------------------------------------------------------------------------
// xcfi_trace_fifo
// DEPTH-entry ring buffer of retirement records. A push into a full buffer
// overwrites the oldest entry, and the head moves along with it.
// Ports:
//   clock, reset     : clock, synchronous active-high reset
//   push_i, rec_i    : write one record
//   pop_i            : drop the head record (ignored when empty)
//   rec_o            : head (oldest) record, raw storage (caller masks)
//   count_o          : records held, 0..DEPTH
//   overwrite_o      : high in a cycle where a push discards the oldest entry
// ----------------------------------------------------------------------------
module xcfi_trace_fifo
   import xcfi_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            push_i,
   input  xcfi_trace_rec_t rec_i,
   input  logic            pop_i,
   output xcfi_trace_rec_t rec_o,
   output logic [AW:0]     count_o,
   output logic            overwrite_o
);

   xcfi_trace_rec_t mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW:0]     count_q;
   logic            full;
   logic            do_pop;

   assign full        = (count_q == (AW+1)'(DEPTH));
   assign do_pop      = pop_i && (count_q != '0);
   assign overwrite_o = push_i && full && !do_pop;
   assign rec_o       = mem_q[rd_ptr_q];
   assign count_o     = count_q;

   // Storage carries no reset; stale contents are masked downstream.
   always_ff @(posedge clock) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= rec_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop || (push_i && full)) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push_i && !do_pop && !full) begin
            count_q <= count_q + 1'b1;
         end else if (do_pop && !push_i) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/xcfi_trace_sampler.sv
// ----------------------------------------------------------------------------
// xcfi_trace_sampler
// Captures RVFI retirements into a ring buffer and checks rvfi_order / PC
// continuity across consecutive retirements. On check the buffer freezes so
// the downstream checker can pop a stable window, oldest record first.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | nothing captured since reset
//   COLLECT | capturing retirements, overwriting the oldest when full
//   HOLD    | frozen window; only pops change the buffer; left by reset only
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   check                   : freeze strobe
//   rvfi_*                  : retirement record in
//   snap_pop                : pop the head record (HOLD only)
//   snap_valid, snap_*      : head record out, zero unless snap_valid
//   snap_count              : records held
//   err_order, err_pc       : sticky continuity errors
//   overflow                : sticky, a record was overwritten
// ----------------------------------------------------------------------------
module xcfi_trace_sampler
   import xcfi_pkg::*;
#(
   parameter  int XLEN  = XCFI_XLEN,
   parameter  int ILEN  = XCFI_ILEN,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    check,
   input  logic                    rvfi_valid,
   input  logic [XCFI_ORDER_W-1:0] rvfi_order,
   input  logic [ILEN-1:0]         rvfi_insn,
   input  logic                    rvfi_trap,
   input  logic                    rvfi_intr,
   input  logic [XLEN-1:0]         rvfi_pc_rdata,
   input  logic [XLEN-1:0]         rvfi_pc_wdata,
   input  logic [4:0]              rvfi_rd_addr,
   input  logic [XLEN-1:0]         rvfi_rd_wdata,
   input  logic                    snap_pop,
   output logic                    snap_valid,
   output logic [XCFI_ORDER_W-1:0] snap_order,
   output logic [ILEN-1:0]         snap_insn,
   output logic                    snap_trap,
   output logic [XLEN-1:0]         snap_pc_rdata,
   output logic [XLEN-1:0]         snap_pc_wdata,
   output logic [4:0]              snap_rd_addr,
   output logic [XLEN-1:0]         snap_rd_wdata,
   output logic [CW-1:0]           snap_count,
   output logic                    err_order,
   output logic                    err_pc,
   output logic                    overflow
);

   xcfi_smp_state_t         state_q;
   logic                    prev_valid_q;
   logic [XCFI_ORDER_W-1:0] prev_order_q;
   logic [XLEN-1:0]         prev_pc_wdata_q;
   logic                    prev_trap_q;
   logic                    err_order_q;
   logic                    err_pc_q;
   logic                    overflow_q;

   xcfi_trace_rec_t rec_in;
   xcfi_trace_rec_t rec_head;
   logic            push;
   logic            pop;
   logic            overwrite;
   logic [CW-1:0]   count;
   logic            order_bad;
   logic            pc_bad;

   assign rec_in = '{
      order:    rvfi_order,
      insn:     rvfi_insn,
      trap:     rvfi_trap,
      pc_rdata: rvfi_pc_rdata,
      pc_wdata: rvfi_pc_wdata,
      rd_addr:  rvfi_rd_addr,
      rd_wdata: rvfi_rd_wdata
   };

   // A retirement coincident with check is still pushed: the state only
   // turns to HOLD after this edge.
   assign push = rvfi_valid && (state_q != XCFI_HOLD);
   assign pop  = snap_pop && (state_q == XCFI_HOLD);

   xcfi_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (push),
      .rec_i       (rec_in),
      .pop_i       (pop),
      .rec_o       (rec_head),
      .count_o     (count),
      .overwrite_o (overwrite)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= XCFI_IDLE;
      end else begin
         case (state_q)
            XCFI_IDLE: begin
               if (check) begin
                  state_q <= XCFI_HOLD;
               end else if (rvfi_valid) begin
                  state_q <= XCFI_COLLECT;
               end
            end
            XCFI_COLLECT: begin
               if (check) begin
                  state_q <= XCFI_HOLD;
               end
            end
            XCFI_HOLD: begin
               state_q <= XCFI_HOLD;
            end
            default: begin
               state_q <= XCFI_IDLE;
            end
         endcase
      end
   end

   // The order increment wraps modulo 2^64 through plain width truncation.
   assign order_bad = rvfi_valid && prev_valid_q &&
                      (rvfi_order != (prev_order_q + 64'd1));
   // A trapping predecessor or an interrupt entry legitimately redirects the PC.
   assign pc_bad    = rvfi_valid && prev_valid_q && !rvfi_intr && !prev_trap_q &&
                      (rvfi_pc_rdata != prev_pc_wdata_q);

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_valid_q    <= 1'b0;
         prev_order_q    <= '0;
         prev_pc_wdata_q <= '0;
         prev_trap_q     <= 1'b0;
         err_order_q     <= 1'b0;
         err_pc_q        <= 1'b0;
         overflow_q      <= 1'b0;
      end else begin
         if (rvfi_valid) begin
            prev_valid_q    <= 1'b1;
            prev_order_q    <= rvfi_order;
            prev_pc_wdata_q <= rvfi_pc_wdata;
            prev_trap_q     <= rvfi_trap;
         end
         if (order_bad) begin
            err_order_q <= 1'b1;
         end
         if (pc_bad) begin
            err_pc_q <= 1'b1;
         end
         if (overwrite) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign snap_valid    = (state_q == XCFI_HOLD) && (count != '0);
   assign snap_count    = count;
   assign snap_order    = snap_valid ? rec_head.order    : '0;
   assign snap_insn     = snap_valid ? rec_head.insn     : '0;
   assign snap_trap     = snap_valid ? rec_head.trap     : 1'b0;
   assign snap_pc_rdata = snap_valid ? rec_head.pc_rdata : '0;
   assign snap_pc_wdata = snap_valid ? rec_head.pc_wdata : '0;
   assign snap_rd_addr  = snap_valid ? rec_head.rd_addr  : '0;
   assign snap_rd_wdata = snap_valid ? rec_head.rd_wdata : '0;
   assign err_order     = err_order_q;
   assign err_pc        = err_pc_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_xcfi_trace_sampler.sv
module tb_xcfi_trace_sampler;
   import xcfi_pkg::*;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0, check = 1'b0, rvfi_valid = 1'b0;
   logic        rvfi_trap = 1'b0, rvfi_intr = 1'b0, snap_pop = 1'b0;
   logic [63:0] rvfi_order = '0;
   logic [31:0] rvfi_insn = '0, rvfi_pc_rdata = '0, rvfi_pc_wdata = '0, rvfi_rd_wdata = '0;
   logic [4:0]  rvfi_rd_addr = '0;

   logic        snap_valid, snap_trap, err_order, err_pc, overflow;
   logic [63:0] snap_order;
   logic [31:0] snap_insn, snap_pc_rdata, snap_pc_wdata, snap_rd_wdata;
   logic [4:0]  snap_rd_addr;
   logic [2:0]  snap_count;

   always #5 clock = ~clock;

   xcfi_trace_sampler #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .check(check), .rvfi_valid(rvfi_valid),
      .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
      .rvfi_intr(rvfi_intr), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
      .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata), .snap_pop(snap_pop),
      .snap_valid(snap_valid), .snap_order(snap_order), .snap_insn(snap_insn),
      .snap_trap(snap_trap), .snap_pc_rdata(snap_pc_rdata), .snap_pc_wdata(snap_pc_wdata),
      .snap_rd_addr(snap_rd_addr), .snap_rd_wdata(snap_rd_wdata), .snap_count(snap_count),
      .err_order(err_order), .err_pc(err_pc), .overflow(overflow)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [31:0] insn_of(input logic [63:0] ord);
      return ord[31:0] ^ 32'h0000_0013;
   endfunction
   function automatic logic [31:0] rdw_of(input logic [31:0] pcr);
      return pcr ^ 32'hA5A5_0000;
   endfunction

   // Apply one cycle of inputs, then return at the following falling edge.
   task automatic drive(input logic rst, val, chk, pop, input logic [63:0] ord,
                        input logic [31:0] pcr, pcw, input logic intr, trap);
      reset = rst; rvfi_valid = val; check = chk; snap_pop = pop;
      rvfi_order = ord; rvfi_pc_rdata = pcr; rvfi_pc_wdata = pcw;
      rvfi_intr = intr; rvfi_trap = trap;
      rvfi_insn = insn_of(ord); rvfi_rd_addr = ord[4:0]; rvfi_rd_wdata = rdw_of(pcr);
      @(posedge clock);
      @(negedge clock);
   endtask

   // ---------------- table-driven vectors ----------------
   typedef struct {
      logic        rst, val, chk, pop;
      logic [63:0] ord;
      logic [31:0] pcr, pcw;
      logic        intr, trap;
      int          e_cnt;
      logic        e_sv;
      logic [63:0] e_ord;
      logic        e_eo, e_ep, e_ov;
   } vec_t;

   vec_t vt[$];

   function automatic void add(input logic rst, val, chk, pop, input logic [63:0] ord,
                               input logic [31:0] pcr, pcw, input logic intr, trap,
                               input int cnt, input logic sv, input logic [63:0] eord,
                               input logic eo, ep, ov);
      vec_t v;
      v.rst = rst; v.val = val; v.chk = chk; v.pop = pop; v.ord = ord;
      v.pcr = pcr; v.pcw = pcw; v.intr = intr; v.trap = trap;
      v.e_cnt = cnt; v.e_sv = sv; v.e_ord = eord; v.e_eo = eo; v.e_ep = ep; v.e_ov = ov;
      vt.push_back(v);
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      logic [63:0] ord;
      logic [31:0] pcr, pcw;
      logic        trap;
   } mrec_t;

   mrec_t       mq[$];
   bit          m_frozen, m_pv, m_ptrap, m_eo, m_ep, m_ov;
   logic [63:0] m_pord;
   logic [31:0] m_ppcw;

   function automatic void model_step(input bit rst, val, chk, pop, input logic [63:0] ord,
                                      input logic [31:0] pcr, pcw, input bit intr, trap);
      bit was_frozen;
      mrec_t r;
      if (rst) begin
         mq.delete();
         m_frozen = 0; m_pv = 0; m_ptrap = 0; m_eo = 0; m_ep = 0; m_ov = 0;
         m_pord = '0; m_ppcw = '0;
         return;
      end
      was_frozen = m_frozen;
      if (val) begin
         if (m_pv && ord != m_pord + 64'd1) m_eo = 1;
         if (m_pv && !intr && !m_ptrap && pcr != m_ppcw) m_ep = 1;
         m_pv = 1; m_pord = ord; m_ppcw = pcw; m_ptrap = trap;
         if (!was_frozen) begin
            if (mq.size() == DEPTH) begin
               void'(mq.pop_front());
               m_ov = 1;
            end
            r.ord = ord; r.pcr = pcr; r.pcw = pcw; r.trap = trap;
            mq.push_back(r);
         end
      end
      if (!was_frozen && chk) m_frozen = 1;
      if (was_frozen && pop && mq.size() > 0) void'(mq.pop_front());
   endfunction

   initial begin
      logic [63:0] g_ord;
      logic [31:0] g_pc, pcr, pcw;
      bit          rst, val, chk, pop, intr, trap, m_sv;

      @(negedge clock);

      // Basic ordering
      add(1,0,0,0, 0, 32'h0, 32'h0, 0,0,  0,0,0, 0,0,0);
      add(0,1,0,0, 0, 32'h0, 32'h4, 0,0,  1,0,0, 0,0,0);
      add(0,1,0,0, 1, 32'h4, 32'h8, 0,0,  2,0,0, 0,0,0);
      add(0,1,0,0, 2, 32'h8, 32'hC, 0,0,  3,0,0, 0,0,0);
      add(0,0,1,0, 0, 32'h0, 32'h0, 0,0,  3,1,0, 0,0,0);
      add(0,0,0,1, 0, 32'h0, 32'h0, 0,0,  2,1,1, 0,0,0);
      add(0,0,0,1, 0, 32'h0, 32'h0, 0,0,  1,1,2, 0,0,0);
      add(0,0,0,1, 0, 32'h0, 32'h0, 0,0,  0,0,0, 0,0,0);
      add(0,0,0,1, 0, 32'h0, 32'h0, 0,0,  0,0,0, 0,0,0);
      // Overflow: six records into four entries
      add(1,0,0,0, 0, 32'h0, 32'h0, 0,0,  0,0,0, 0,0,0);
      for (int i = 0; i < 6; i++)
         add(0,1,0,0, 64'(i), 32'(4*i), 32'(4*i+4), 0,0,
             (i < 4) ? i + 1 : 4, 0, 0, 0, 0, (i >= 4) ? 1'b1 : 1'b0);
      add(0,0,1,0, 0, 32'h0, 32'h0, 0,0,  4,1,2, 0,0,1);
      add(0,1,0,0, 6, 32'd24, 32'd28, 0,0, 4,1,2, 0,0,1);
      // Order skip 5 -> 7, sticky
      add(1,0,0,0, 0, 32'h0, 32'h0, 0,0,  0,0,0, 0,0,0);
      add(0,1,0,0, 5, 32'h0, 32'h4, 0,0,  1,0,0, 0,0,0);
      add(0,1,0,0, 7, 32'h4, 32'h8, 0,0,  2,0,0, 1,0,0);
      add(0,0,0,0, 0, 32'h0, 32'h0, 0,0,  2,0,0, 1,0,0);
      add(0,1,0,0, 8, 32'h8, 32'hC, 0,0,  3,0,0, 1,0,0);
      // PC discontinuity, then excused by intr and by a trapping predecessor
      add(1,0,0,0, 0, 32'h0, 32'h0, 0,0,  0,0,0, 0,0,0);
      add(0,1,0,0, 0, 32'hC, 32'h10, 0,0, 1,0,0, 0,0,0);
      add(0,1,0,0, 1, 32'h20, 32'h24, 0,0, 2,0,0, 0,1,0);
      add(1,0,0,0, 0, 32'h0, 32'h0, 0,0,  0,0,0, 0,0,0);
      add(0,1,0,0, 0, 32'hC, 32'h10, 0,0, 1,0,0, 0,0,0);
      add(0,1,0,0, 1, 32'h20, 32'h24, 1,0, 2,0,0, 0,0,0);
      add(0,1,0,0, 2, 32'h24, 32'h28, 0,1, 3,0,0, 0,0,0);
      add(0,1,0,0, 3, 32'h100, 32'h104, 0,0, 4,0,0, 0,0,0);
      // check coincident with retire
      add(1,0,0,0, 0, 32'h0, 32'h0, 0,0,  0,0,0, 0,0,0);
      add(0,1,0,0, 8, 32'h0, 32'h4, 0,0,  1,0,0, 0,0,0);
      add(0,1,1,0, 9, 32'h4, 32'h8, 0,0,  2,1,8, 0,0,0);
      add(0,1,0,0, 10, 32'h8, 32'hC, 0,0, 2,1,8, 0,0,0);
      add(0,0,0,1, 0, 32'h0, 32'h0, 0,0,  1,1,9, 0,0,0);
      // check from IDLE freezes an empty buffer
      add(1,0,0,0, 0, 32'h0, 32'h0, 0,0,  0,0,0, 0,0,0);
      add(0,0,1,0, 0, 32'h0, 32'h0, 0,0,  0,0,0, 0,0,0);
      add(0,1,0,0, 0, 32'h0, 32'h4, 0,0,  0,0,0, 0,0,0);

      foreach (vt[i]) begin
         drive(vt[i].rst, vt[i].val, vt[i].chk, vt[i].pop, vt[i].ord,
               vt[i].pcr, vt[i].pcw, vt[i].intr, vt[i].trap);
         cmp($sformatf("v%0d count", i), 64'(snap_count), 64'(vt[i].e_cnt));
         cmp($sformatf("v%0d valid", i), 64'(snap_valid), 64'(vt[i].e_sv));
         if (vt[i].e_sv) cmp($sformatf("v%0d order", i), snap_order, vt[i].e_ord);
         cmp($sformatf("v%0d err_order", i), 64'(err_order), 64'(vt[i].e_eo));
         cmp($sformatf("v%0d err_pc", i), 64'(err_pc), 64'(vt[i].e_ep));
         cmp($sformatf("v%0d overflow", i), 64'(overflow), 64'(vt[i].e_ov));
      end

      // Reset while holding three records with both error flags raised
      drive(1,0,0,0, 0, 32'h0, 32'h0, 0,0);
      drive(0,1,0,0, 0, 32'h0, 32'h4, 0,0);
      drive(0,1,0,0, 1, 32'h4, 32'h8, 0,0);
      drive(0,1,0,0, 5, 32'h40, 32'h44, 0,0);
      drive(0,0,1,0, 0, 32'h0, 32'h0, 0,0);
      cmp("hold count", 64'(snap_count), 64'd3);
      cmp("hold head pc_wdata", 64'(snap_pc_wdata), 64'h4);
      cmp("hold head insn", 64'(snap_insn), 64'(insn_of(64'd0)));
      cmp("hold err_order", 64'(err_order), 64'd1);
      cmp("hold err_pc", 64'(err_pc), 64'd1);
      drive(1,0,0,0, 0, 32'h0, 32'h0, 0,0);
      cmp("rst valid", 64'(snap_valid), 64'd0);
      cmp("rst count", 64'(snap_count), 64'd0);
      cmp("rst order", snap_order, 64'd0);
      cmp("rst insn", 64'(snap_insn), 64'd0);
      cmp("rst trap", 64'(snap_trap), 64'd0);
      cmp("rst pc_rdata", 64'(snap_pc_rdata), 64'd0);
      cmp("rst pc_wdata", 64'(snap_pc_wdata), 64'd0);
      cmp("rst rd_addr", 64'(snap_rd_addr), 64'd0);
      cmp("rst rd_wdata", 64'(snap_rd_wdata), 64'd0);
      cmp("rst err_order", 64'(err_order), 64'd0);
      cmp("rst err_pc", 64'(err_pc), 64'd0);
      cmp("rst overflow", 64'(overflow), 64'd0);
      drive(0,1,0,0, 100, 32'h200, 32'h204, 0,0);
      cmp("post-rst err_order", 64'(err_order), 64'd0);
      cmp("post-rst err_pc", 64'(err_pc), 64'd0);
      cmp("post-rst count", 64'(snap_count), 64'd1);

      // Randomized run against the queue model
      g_ord = 64'hFFFF_FFFF_FFFF_FFFD;  // exercises the 64-bit wrap
      g_pc  = 32'h1000;
      for (int cyc = 0; cyc < 900; cyc++) begin
         rst  = (cyc % 150 == 0) || ($urandom_range(0, 299) == 0);
         val  = ($urandom_range(0, 99) < 60);
         chk  = ($urandom_range(0, 99) < 3);
         pop  = ($urandom_range(0, 99) < 40);
         intr = ($urandom_range(0, 99) < 5);
         trap = ($urandom_range(0, 99) < 8);
         if (val) begin
            g_ord = g_ord + (($urandom_range(0, 99) < 4) ? 64'd2 : 64'd1);
            pcr   = ($urandom_range(0, 99) < 5) ? $urandom() : g_pc;
            pcw   = ($urandom_range(0, 99) < 10) ? $urandom() : pcr + 32'd4;
            g_pc  = pcw;
         end else begin
            pcr = $urandom();
            pcw = $urandom();
         end
         model_step(rst, val, chk, pop, g_ord, pcr, pcw, intr, trap);
         drive(rst, val, chk, pop, g_ord, pcr, pcw, intr, trap);
         m_sv = m_frozen && (mq.size() > 0);
         cmp($sformatf("r%0d count", cyc), 64'(snap_count), 64'(mq.size()));
         cmp($sformatf("r%0d valid", cyc), 64'(snap_valid), 64'(m_sv));
         cmp($sformatf("r%0d err_order", cyc), 64'(err_order), 64'(m_eo));
         cmp($sformatf("r%0d err_pc", cyc), 64'(err_pc), 64'(m_ep));
         cmp($sformatf("r%0d overflow", cyc), 64'(overflow), 64'(m_ov));
         if (m_sv) begin
            cmp($sformatf("r%0d order", cyc), snap_order, mq[0].ord);
            cmp($sformatf("r%0d pc_rdata", cyc), 64'(snap_pc_rdata), 64'(mq[0].pcr));
            cmp($sformatf("r%0d pc_wdata", cyc), 64'(snap_pc_wdata), 64'(mq[0].pcw));
            cmp($sformatf("r%0d trap", cyc), 64'(snap_trap), 64'(mq[0].trap));
            cmp($sformatf("r%0d insn", cyc), 64'(snap_insn), 64'(insn_of(mq[0].ord)));
            cmp($sformatf("r%0d rd_addr", cyc), 64'(snap_rd_addr), 64'(mq[0].ord[4:0]));
            cmp($sformatf("r%0d rd_wdata", cyc), 64'(snap_rd_wdata), 64'(rdw_of(mq[0].pcr)));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/xcfi_trace_sampler.md
# xcfi_trace_sampler

Sits between `xcfi_wrapper` and `xcfi_insn_checker` in the XCFI formal testbench. It captures RVFI retirement records into a small ring buffer and runs cross-instruction continuity checks on `rvfi_order` and the PC. When the testbench `check` strobe fires, it freezes the buffer so the checker can pop a stable, ordered window of the most recent retirements.

## Interface

Parameters:
- `XLEN`, 32: data/PC width.
- `ILEN`, 32: instruction width.
- `DEPTH`, 4: buffer entries; power of two, ≥2.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `check`  in  1  freeze strobe from the testbench cycle counter.
- `rvfi_valid`  in  1  retirement valid.
- `rvfi_order`  in  64  retirement index.
- `rvfi_insn`  in  ILEN  retired instruction.
- `rvfi_trap`  in  1  instruction trapped.
- `rvfi_intr`  in  1  first instruction of a trap handler.
- `rvfi_pc_rdata`  in  XLEN  PC of the instruction.
- `rvfi_pc_wdata`  in  XLEN  next PC.
- `rvfi_rd_addr`  in  5  destination register.
- `rvfi_rd_wdata`  in  XLEN  destination write data.
- `snap_pop`  in  1  consumer pops the head record (HOLD only).
- `snap_valid`  out  1  head record presented, in HOLD only.
- `snap_order`, `snap_insn`, `snap_trap`, `snap_pc_rdata`, `snap_pc_wdata`, `snap_rd_addr`, `snap_rd_wdata`  out  per-field widths  head (oldest) record fields.
- `snap_count`  out  $clog2(DEPTH)+1  records currently held.
- `err_order`  out  1  sticky: order discontinuity seen.
- `err_pc`  out  1  sticky: PC discontinuity seen.
- `overflow`  out  1  sticky: a record was overwritten.

## Operation

States: IDLE, COLLECT, HOLD.
- **IDLE**
  - `rvfi_valid` pushes the record and moves to COLLECT.
  - `check` moves to HOLD with an empty buffer.
- **COLLECT**
  - Each `rvfi_valid` pushes one record.
  - If the buffer is full, the oldest record is overwritten, `snap_count` stays at DEPTH, and `overflow` is set.
  - `check` moves to HOLD.
- **HOLD**
  - No further pushes occur.
  - Exits only on `reset`.
- `check` coincident with `rvfi_valid`: the record is pushed first, then the block freezes, so the record is part of the window.
- `snap_pop` in HOLD with `snap_count`≠0 removes the head.
  - Ignored when empty.
  - Ignored outside HOLD.
- Continuity checks run in every state, including HOLD. They use a "previous record" register (`prev_valid`, `prev_order`, `prev_pc_wdata`, `prev_trap`) that updates on every `rvfi_valid`.
  - **Order check:** with `prev_valid`, `rvfi_order` ≠ `prev_order`+1 (modulo 2^64) sets `err_order`.
  - **PC check:** with `prev_valid`, and neither `rvfi_intr` nor `prev_trap` set, `rvfi_pc_rdata` ≠ `prev_pc_wdata` sets `err_pc`.
  - `rvfi_valid` low: no check, no update.
- Error flags are sticky until reset.
- Reset mid-operation discards all records and previous-record state.
- Reset values:
  - All outputs 0; state IDLE.
  - Pointers 0; `prev_valid` 0.
  - Storage contents are don't-care, masked by `snap_valid`.

## Timing

- Push is registered: a record accepted at edge N is counted in `snap_count` after edge N.
- `snap_valid` rises the cycle after the edge that samples `check`. It stays high while `snap_count`≠0.
- `snap_*` outputs come from storage/pointer registers only; there is no combinational path from `rvfi_*`.
- A pop at edge N advances the head, so the next record is visible after edge N. Back-to-back pops are legal, one per cycle.
- Error and overflow flags assert the cycle after the offending retirement.

## Structure

- Package `xcfi_pkg` holds:
  - `xcfi_trace_rec_t`: packed struct of the stored fields.
  - `xcfi_smp_state_t`: state enum.
  - `XCFI_ORDER_W`=64.
- Sub-module `xcfi_trace_fifo`: DEPTH-entry ring buffer of `xcfi_trace_rec_t`.
  - Push with overwrite-on-full.
  - Pop, count, and an overwrite pulse.
- The top level holds the FSM, previous-record register, and the checks.

## Test plan

- **Basic ordering:** retire orders 0,1,2 with PCs 0x0→0x4→0x8 contiguous, then `check`. Required: `snap_count`=3, `snap_order`=0; after three pops, orders 1 and 2 appear in turn, `snap_valid`=0, and no error flags.
- **Overflow:** retire 6 records with DEPTH=4, then `check`. Required: `snap_order`=2, `snap_count`=4, `overflow`=1.
- **Order skip:** retire order 5 then order 7. Required: `err_order`=1 on the cycle after the second retirement, and it stays 1 until reset.
- **PC discontinuity:**
  - First record `pc_wdata`=0x10, next `pc_rdata`=0x20, `intr`=0 → `err_pc`=1.
  - Repeat with `rvfi_intr`=1 → `err_pc`=0.
- **Simultaneous check and retire:** `check` and `rvfi_valid` in the same cycle with order 9. Required: HOLD entered, record 9 included; a later `rvfi_valid` does not change `snap_count`.
- **Reset in HOLD:** reset with 3 records held. Required: all outputs 0. A new order-100 retirement after reset flags no `err_order`.
